// File: rtl/sha256_pkg.sv
// Shared constants, FSM encoding and control-output bundle for the SHA-256 round controller.
package sha256_pkg;

  localparam int ROUNDS     = 64;
  localparam int MSG_WORDS  = 16;
  localparam int ROUND_LAST = 63;
  localparam int IDX_W      = $clog2(ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // IV[0] is H0; the datapath loads these on init_iv.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef struct packed {
    logic init_iv;
    logic load_work;
    logic round_en;
    logic w_ready;
    logic w_sched_sel;
    logic hash_upd;
    logic busy;
    logic done;
  } ctrl_out_t;

  function automatic logic [31:0] iv_word(input logic [2:0] i);
    return IV[i];
  endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Controller <-> datapath/requester bundle. abort exists only with SHA256_CTRL_ABORT_EN.
interface sha256_round_ctrl_if;
  import sha256_pkg::*;

  logic             start;
  logic             first_blk;
  logic             w_valid;
  logic             w_ready;
  logic             init_iv;
  logic             load_work;
  logic             round_en;
  logic [IDX_W-1:0] round_idx;
  logic             w_sched_sel;
  logic             hash_upd;
  logic             busy;
  logic             done;
`ifdef SHA256_CTRL_ABORT_EN
  logic             abort;

  modport master (
    output start, first_blk, w_valid, abort,
    input  w_ready, init_iv, load_work, round_en, round_idx, w_sched_sel, hash_upd, busy, done
  );
  modport slave (
    input  start, first_blk, w_valid, abort,
    output w_ready, init_iv, load_work, round_en, round_idx, w_sched_sel, hash_upd, busy, done
  );
`else
  modport master (
    output start, first_blk, w_valid,
    input  w_ready, init_iv, load_work, round_en, round_idx, w_sched_sel, hash_upd, busy, done
  );
  modport slave (
    input  start, first_blk, w_valid,
    output w_ready, init_iv, load_work, round_en, round_idx, w_sched_sel, hash_upd, busy, done
  );
`endif

endinterface

// File: rtl/sha256_round_cnt.sv
// Round counter: 6-bit, clear beats enable, wraps 63 -> 0, terminal flag at the last round.
module sha256_round_cnt
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             last_o
);

  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == IDX_W'(ROUND_LAST));

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round controller (IDLE/INIT/LOAD/ROUND/UPDATE/DONE).
// Optional abort input enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  sha256_round_ctrl_if.slave ctrl
);

  state_e           state_q, state_d;
  logic             first_blk_q, first_blk_d;
  ctrl_out_t        out;
  logic [IDX_W-1:0] idx;
  logic             idx_last;
  logic             cnt_clr;
  logic             abort_act;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_act = ctrl.abort && (state_q != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  sha256_round_cnt u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (out.round_en),
    .cnt_o  (idx),
    .last_o (idx_last)
  );

  always_comb begin
    state_d     = state_q;
    first_blk_d = first_blk_q;
    out         = '0;
    cnt_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (ctrl.start) begin
          first_blk_d = ctrl.first_blk;
          state_d     = ctrl.first_blk ? ST_INIT : ST_LOAD;
        end
      end
      ST_INIT: begin
        out.busy    = 1'b1;
        out.init_iv = first_blk_q;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        out.busy      = 1'b1;
        out.load_work = 1'b1;
        cnt_clr       = 1'b1;
        state_d       = ST_ROUND;
      end
      ST_ROUND: begin
        out.busy = 1'b1;
        // First 16 rounds take W from the input port and may stall; later rounds never stall.
        if (idx < IDX_W'(MSG_WORDS)) begin
          out.w_ready  = 1'b1;
          out.round_en = ctrl.w_valid;
        end else begin
          out.w_sched_sel = 1'b1;
          out.round_en    = 1'b1;
        end
        if (out.round_en && idx_last) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        out.busy     = 1'b1;
        out.hash_upd = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        out.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d      = ST_IDLE;
      out.round_en = 1'b0;
      out.hash_upd = 1'b0;
      out.done     = 1'b0;
      cnt_clr      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      first_blk_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_blk_q <= first_blk_d;
    end
  end

  assign ctrl.init_iv     = out.init_iv;
  assign ctrl.load_work   = out.load_work;
  assign ctrl.round_en    = out.round_en;
  assign ctrl.w_ready     = out.w_ready;
  assign ctrl.w_sched_sel = out.w_sched_sel;
  assign ctrl.hash_upd    = out.hash_upd;
  assign ctrl.busy        = out.busy;
  assign ctrl.done        = out.done;
  assign ctrl.round_idx   = idx;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: expected pulse cycles are queued at start and
// popped by a negedge monitor that also tracks the round index sequence.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  int q_init[$], q_load[$], q_upd[$], q_done[$];
  int idx_exp = 0, nrounds = 0, wr_cnt = 0, load_cyc = 0, exp_stall = 0;

  sha256_round_ctrl_if ctrl();

  sha256_round_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [13:0] outs();
    return {ctrl.init_iv, ctrl.load_work, ctrl.round_en, ctrl.w_ready, ctrl.w_sched_sel,
            ctrl.hash_upd, ctrl.busy, ctrl.done, ctrl.round_idx};
  endfunction

  function automatic int pending();
    return q_init.size() + q_load.size() + q_upd.size() + q_done.size();
  endfunction

  // Monitor: pulses against queued cycles, round index sequence, w_ready accounting.
  always @(negedge clk) begin
    if (ctrl.init_iv === 1'b1) begin
      chk("init_iv_expected", q_init.size() != 0, 1);
      if (q_init.size() != 0) chk("init_iv_cycle", cyc, q_init.pop_front());
    end
    if (ctrl.load_work === 1'b1) begin
      chk("load_work_expected", q_load.size() != 0, 1);
      if (q_load.size() != 0) chk("load_work_cycle", cyc, q_load.pop_front());
      load_cyc = cyc; idx_exp = 0; nrounds = 0; wr_cnt = 0;
    end
    if (ctrl.w_ready === 1'b1) begin
      wr_cnt++;
      chk("round_en_follows_w_valid", ctrl.round_en, ctrl.w_valid);
    end
    if (ctrl.round_en === 1'b1) begin
      chk("round_idx_seq", ctrl.round_idx, idx_exp);
      chk("w_sched_sel", ctrl.w_sched_sel, idx_exp >= 16);
      if (idx_exp == 0) chk("first_round_cycle", cyc, load_cyc + 1);
      idx_exp++; nrounds++;
    end
    if (ctrl.hash_upd === 1'b1) begin
      chk("round_count", nrounds, 64);
      chk("w_ready_cycles", wr_cnt, 16 + exp_stall);
      chk("hash_upd_expected", q_upd.size() != 0, 1);
      if (q_upd.size() != 0) chk("hash_upd_cycle", cyc, q_upd.pop_front());
    end
    if (ctrl.done === 1'b1) begin
      chk("busy_low_in_done", ctrl.busy, 0);
      chk("done_expected", q_done.size() != 0, 1);
      if (q_done.size() != 0) chk("done_cycle", cyc, q_done.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_blk(input bit fb, input bit full);
    int t;
    t = cyc;
    ctrl.start = 1'b1;
    ctrl.first_blk = fb;
    if (fb) begin
      q_init.push_back(t + 1);
      q_load.push_back(t + 2);
    end else begin
      q_load.push_back(t + 1);
    end
    if (full) begin
      q_upd.push_back(t + (fb ? 67 : 66) + exp_stall);
      q_done.push_back(t + (fb ? 68 : 67) + exp_stall);
    end
    tick();
    ctrl.start = 1'b0;
    ctrl.first_blk = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin tick(); n++; end
    chk("drain_in_budget", n < budget, 1);
    tick();
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(ctrl.busy === 1'b1 && ctrl.load_work === 1'b0 && ctrl.round_idx == idx) && n < 200) begin
      tick(); n++;
    end
    chk("reach_round_idx", n < 200, 1);
  endtask

  initial begin
    ctrl.start = 1'b0;
    ctrl.first_blk = 1'b0;
    ctrl.w_valid = 1'b1;
`ifdef SHA256_CTRL_ABORT_EN
    ctrl.abort = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", outs(), 0);

    // First block from IV, no stalls.
    start_blk(1'b1, 1'b1);
    chk("busy_in_init", ctrl.busy, 1);
    drain(200);

    // Continuation block: no init_iv.
    start_blk(1'b0, 1'b1);
    chk("no_init_iv", ctrl.init_iv, 0);
    chk("load_after_start", ctrl.load_work, 1);
    drain(200);

    // Five stall cycles at round 7.
    exp_stall = 5;
    start_blk(1'b0, 1'b1);
    wait_idx(7);
    ctrl.w_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_round_en", ctrl.round_en, 0);
      chk("stall_idx_held", ctrl.round_idx, 7);
      tick();
    end
    ctrl.w_valid = 1'b1;
    drain(200);
    exp_stall = 0;

    // start while busy is ignored.
    start_blk(1'b0, 1'b1);
    wait_idx(30);
    ctrl.start = 1'b1;
    ctrl.first_blk = 1'b1;
    tick();
    ctrl.start = 1'b0;
    ctrl.first_blk = 1'b0;
    drain(200);

    // start during DONE is ignored.
    start_blk(1'b1, 1'b1);
    begin
      int n = 0;
      while (ctrl.done !== 1'b1 && n < 200) begin tick(); n++; end
      chk("reach_done", n < 200, 1);
    end
    ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
    chk("idle_after_done_start", outs(), 0);
    repeat (5) tick();
    chk("not_restarted", ctrl.busy, 0);
    chk("queues_empty_after_done", pending(), 0);

    // Reset mid-block at round 40.
    start_blk(1'b1, 1'b0);
    wait_idx(40);
    rst_n = 1'b0;
    tick();
    chk("mid_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    repeat (80) tick();
    chk("queues_empty_after_reset", pending(), 0);
    start_blk(1'b0, 1'b1);
    drain(200);

`ifdef SHA256_CTRL_ABORT_EN
    start_blk(1'b1, 1'b0);
    wait_idx(20);
    ctrl.abort = 1'b1;
    @(negedge clk);
    chk("abort_no_round_en", ctrl.round_en, 0);
    tick();
    ctrl.abort = 1'b0;
    chk("abort_idle_outputs", outs(), 0);
    repeat (70) tick();
    chk("abort_no_done", pending(), 0);

    start_blk(1'b0, 1'b0);
    begin
      int n = 0;
      while (ctrl.busy !== 1'b1 || ctrl.round_en === 1'b1 || ctrl.load_work === 1'b1 ||
             ctrl.round_idx != 0 || n < 60) begin
        if (n >= 200) break;
        tick(); n++;
      end
      chk("reach_update", n < 200, 1);
    end
    ctrl.abort = 1'b1;
    @(negedge clk);
    chk("abort_suppresses_hash_upd", ctrl.hash_upd, 0);
    tick();
    ctrl.abort = 1'b0;
    chk("abort_update_idle", outs(), 0);
    repeat (5) tick();
    chk("abort_update_no_done", pending(), 0);
`endif

    chk("final_queues_empty", pending(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameters: none; all sizes are fixed constants in the shared package.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  begin processing one 512-bit block; sampled only in IDLE.
REQ-005 first_blk  in  1  sampled with start; 1 = initialise hash state H0..H7 from IV.
REQ-006 w_valid  in  1  message word available on datapath input (rounds 0..15).
REQ-007 w_ready  out  1  controller consumes the message word this cycle when w_valid=1.
REQ-008 init_iv  out  1  pulse; datapath loads H0..H7 <= IV (6a09e667, bb67ae85, 3c6ef372, ...).
REQ-009 load_work  out  1  pulse; datapath loads a..h <= H0..H7.
REQ-010 round_en  out  1  datapath executes one compression round (Ch, Ma, Sigma, T1/T2) this cycle.
REQ-011 round_idx  out  6  current round number 0..63; also K-ROM address.
REQ-012 w_sched_sel  out  1  0 = W from input word, 1 = W from message schedule.
REQ-013 hash_upd  out  1  pulse; datapath performs H_i <= H_i + working var (mod 2^32).
REQ-014 busy  out  1  high from the cycle after start is accepted through the UPDATE state.
REQ-015 done  out  1  single-cycle pulse; block complete and H valid.
REQ-016 abort  in  1  present only when SHA256_CTRL_ABORT_EN is defined.

Function
REQ-017 FSM states: IDLE, INIT, LOAD, ROUND, UPDATE, DONE; binary encoding from package.
REQ-018 IDLE: start=1 -> INIT if first_blk=1, else LOAD; start is ignored in all other states.
REQ-019 INIT: init_iv=1 for exactly one cycle -> LOAD.
REQ-020 LOAD: load_work=1 for one cycle, round_idx=0 -> ROUND.
REQ-021 ROUND, round_idx<16: w_ready=1, w_sched_sel=0, round_en=w_valid; w_valid=0 stalls (round_idx held, no round_en).
REQ-022 ROUND, round_idx>=16: w_ready=0, w_sched_sel=1, round_en=1 every cycle; no stall.
REQ-023 round_idx increments by 1 on each cycle with round_en=1; round_en at round_idx=63 -> UPDATE and round_idx wraps to 0.
REQ-024 UPDATE: hash_upd=1 one cycle -> DONE; DONE: done=1, busy=0 one cycle -> IDLE.
REQ-025 Latency without stalls, start accepted at cycle T: done at T+68 (first_blk=1), T+67 (first_blk=0); each stall cycle adds 1.
REQ-026 All pulse outputs (init_iv, load_work, hash_upd, done) and round_en/w_ready are zero outside their defined states.
REQ-027 start asserted in the DONE cycle is ignored; a new block needs start in IDLE (minimum 1 idle cycle between blocks).

Reset
REQ-028 rst_n=0 at a clock edge: state=IDLE, round_idx=0, all outputs 0, captured first_blk=0; takes priority over every transition.
REQ-029 Reset mid-block abandons the block: no hash_upd, no done; datapath H contents are not defined by this block.

Configuration
REQ-030 Macro SHA256_CTRL_ABORT_EN defined: abort port exists; abort=1 in any non-IDLE state -> IDLE next cycle, round_en, hash_upd and done suppressed in that cycle, round_idx cleared; abort in IDLE has no effect; rst_n has priority over abort.
REQ-031 Macro undefined: no abort port; behaviour exactly as REQ-017..REQ-029.

Structure
REQ-032 Shared package sha256_pkg: state encodings, ROUNDS=64, MSG_WORDS=16, ROUND_LAST=63, the eight 32-bit IV constants.
REQ-033 One sub-module sha256_round_cnt: 6-bit counter with clear, enable, and terminal flag at 63.

Verification
REQ-034 start=1, first_blk=1 at T, w_valid held 1 -> init_iv at T+1, load_work at T+2, 64 round_en cycles T+3..T+66, hash_upd at T+67, done at T+68.
REQ-035 first_blk=0, w_valid=1 -> no init_iv, done at T+67; w_ready high exactly 16 cycles.
REQ-036 w_valid=0 for 5 cycles at round_idx=7 -> round_idx holds 7, no round_en, done delayed by exactly 5 cycles.
REQ-037 start pulsed while busy at round_idx=30 -> no effect; single done; round_idx sequence 0..63 unbroken.
REQ-038 rst_n=0 at round_idx=40 -> next cycle IDLE, all outputs 0, no hash_upd/done; subsequent start runs a normal block.
REQ-039 With SHA256_CTRL_ABORT_EN: abort=1 at round_idx=20 -> IDLE next cycle, round_idx=0, no done; abort during UPDATE suppresses hash_upd.
